// File: rtl/fir_pkg.sv
// Shared types, widths and the accumulator dequantizer for the serial FIR sequencer.
package fir_pkg;
  localparam int unsigned DEF_TAPS       = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH     = $clog2(DEF_TAPS);
  localparam int unsigned ACC_WIDTH      = 2 * DEF_DATA_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {LOAD, MAC, TAIL, OUT} state_t;

  // Arithmetic right shift, then wrap to the sample width.
  function automatic logic [DEF_DATA_WIDTH-1:0] dequantize(
    input logic signed [ACC_WIDTH-1:0] acc,
    input int unsigned                 bits
  );
    logic signed [ACC_WIDTH-1:0] v_sh;
    v_sh = acc >>> bits;
    return v_sh[DEF_DATA_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/fir_seq_ctrl_mac.sv
// Single multiplier-accumulator: product of the RAM/ROM read data, gated by the
// validity registered alongside the issued address.
module fir_mac import fir_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clear,
  input  logic                         i_issue_valid,
  input  logic signed [DATA_WIDTH-1:0] i_hist,
  input  logic signed [DATA_WIDTH-1:0] i_coeff,
  output logic signed [ACC_WIDTH-1:0]  o_acc_next
);
  logic                           r_valid;
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic signed [2*DATA_WIDTH-1:0] w_hist_ext;
  logic signed [2*DATA_WIDTH-1:0] w_coeff_ext;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_acc_next;

  assign w_hist_ext  = {{DATA_WIDTH{i_hist[DATA_WIDTH-1]}}, i_hist};
  assign w_coeff_ext = {{DATA_WIDTH{i_coeff[DATA_WIDTH-1]}}, i_coeff};
  assign w_prod      = w_hist_ext * w_coeff_ext;
  assign w_acc_next  = r_valid ? r_acc + ACC_WIDTH'(w_prod) : r_acc;
  assign o_acc_next  = w_acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_valid <= i_issue_valid;
      r_acc   <= i_clear ? '0 : w_acc_next;
    end
  end
endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a time-shared FIR: loads DECIMATION samples into the history RAM,
// walks all taps through one MAC, then pushes the dequantized result.
module fir_seq_ctrl import fir_pkg::*; #(
  parameter int unsigned TAPS       = DEF_TAPS,
  parameter int unsigned DECIMATION = 2,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BITS       = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         x_in_empty,
  output logic                         x_in_rd_en,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  output logic                         hist_wr_en,
  output logic [ADDR_WIDTH-1:0]        hist_wr_addr,
  output logic signed [DATA_WIDTH-1:0] hist_wr_data,
  output logic [ADDR_WIDTH-1:0]        hist_rd_addr,
  input  logic signed [DATA_WIDTH-1:0] hist_rd_data,
  output logic [ADDR_WIDTH-1:0]        coeff_addr,
  input  logic signed [DATA_WIDTH-1:0] coeff_data,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic                         y_out_wr_en,
  input  logic                         y_out_full,
  output logic                         busy
);
  localparam logic [ADDR_WIDTH:0]   LAST_LOAD = (ADDR_WIDTH+1)'(DECIMATION - 1);
  localparam logic [ADDR_WIDTH:0]   FILL_MAX  = (ADDR_WIDTH+1)'(TAPS);
  localparam logic [ADDR_WIDTH-1:0] LAST_K    = ADDR_WIDTH'(TAPS - 1);

  state_t                      r_state;
  state_t                      w_state_next;
  logic [ADDR_WIDTH-1:0]       r_wp;
  logic [ADDR_WIDTH-1:0]       r_newest;
  logic [ADDR_WIDTH-1:0]       r_k;
  logic [ADDR_WIDTH:0]         r_load_cnt;
  logic [ADDR_WIDTH:0]         r_fill;
  logic signed [DATA_WIDTH-1:0] r_y_out;
  logic                        w_pop;
  logic                        w_last_pop;
  logic                        w_push;
  logic                        w_issue_valid;
  logic signed [ACC_WIDTH-1:0] w_acc_next;

  always_ff @(posedge clk) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_state_next;
  end

  // Next state and strobes; strobes are forced low while reset is held.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_last_pop   = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      LOAD: begin
        w_pop = !x_in_empty;
        if (w_pop && r_load_cnt == LAST_LOAD) begin
          w_last_pop   = 1'b1;
          w_state_next = MAC;
        end
      end
      MAC:     if (r_k == LAST_K) w_state_next = TAIL;
      TAIL:    w_state_next = OUT;
      OUT: begin
        w_push = !y_out_full;
        if (w_push) w_state_next = LOAD;
      end
      default: w_state_next = LOAD;
    endcase
    if (reset) begin
      w_pop      = 1'b0;
      w_last_pop = 1'b0;
      w_push     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp       <= '0;
      r_newest   <= '0;
      r_load_cnt <= '0;
      r_fill     <= '0;
      r_k        <= '0;
      r_y_out    <= '0;
    end else begin
      if (w_pop) begin
        r_wp       <= r_wp + ADDR_WIDTH'(1);
        r_newest   <= r_wp;
        r_load_cnt <= w_last_pop ? '0 : r_load_cnt + (ADDR_WIDTH+1)'(1);
        if (r_fill != FILL_MAX) r_fill <= r_fill + (ADDR_WIDTH+1)'(1);
      end
      r_k <= (r_state == MAC) ? r_k + ADDR_WIDTH'(1) : '0;
      if (r_state == TAIL) r_y_out <= DATA_WIDTH'(dequantize(w_acc_next, BITS));
    end
  end

  // Taps reaching back past the samples written since reset contribute zero.
  assign w_issue_valid = (r_state == MAC) && ({1'b0, r_k} < r_fill);

  fir_mac #(.DATA_WIDTH(DATA_WIDTH)) u_mac (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (w_last_pop),
    .i_issue_valid (w_issue_valid),
    .i_hist        (hist_rd_data),
    .i_coeff       (coeff_data),
    .o_acc_next    (w_acc_next)
  );

  assign x_in_rd_en   = w_pop;
  assign hist_wr_en   = w_pop;
  assign hist_wr_addr = r_wp;
  assign hist_wr_data = x_in;
  assign hist_rd_addr = r_newest - r_k;
  assign coeff_addr   = r_k;
  assign y_out        = r_y_out;
  assign y_out_wr_en  = w_push;
  assign busy         = !reset && (r_state != LOAD);
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with behavioural history RAM, coefficient ROM and input FIFO.
module tb_fir_seq_ctrl;
  logic               clk = 1'b0;
  logic               reset;
  logic               x_in_empty, x_in_rd_en;
  logic signed [31:0] x_in;
  logic               hist_wr_en;
  logic [4:0]         hist_wr_addr, hist_rd_addr, coeff_addr;
  logic signed [31:0] hist_wr_data, hist_rd_data, coeff_data, y_out;
  logic               y_out_wr_en, y_out_full, busy;

  logic signed [31:0] mem  [0:31];
  logic signed [31:0] coef [0:31];
  logic signed [31:0] src  [0:2047];
  logic               ram_fill;
  logic signed [31:0] ram_fill_val;
  int                 src_cnt = 0;
  int                 rd_ptr  = 0;
  int                 cyc     = 0;
  int                 n_cmp   = 0;
  int                 n_bad   = 0;

  always #5 clk = ~clk;

  fir_seq_ctrl dut (
    .clk(clk), .reset(reset), .x_in_empty(x_in_empty), .x_in_rd_en(x_in_rd_en), .x_in(x_in),
    .hist_wr_en(hist_wr_en), .hist_wr_addr(hist_wr_addr), .hist_wr_data(hist_wr_data),
    .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .y_out(y_out), .y_out_wr_en(y_out_wr_en), .y_out_full(y_out_full),
    .busy(busy)
  );

  always @(posedge clk) begin
    if (ram_fill) for (int i = 0; i < 32; i++) mem[i] <= ram_fill_val;
    else if (hist_wr_en) mem[hist_wr_addr] <= hist_wr_data;
    hist_rd_data <= mem[hist_rd_addr];
    coeff_data   <= coef[coeff_addr];
    if (x_in_rd_en) rd_ptr <= rd_ptr + 1;
    cyc <= cyc + 1;
  end

  assign x_in_empty = (rd_ptr >= src_cnt);
  assign x_in       = src[rd_ptr[10:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic signed [31:0] v);
    src[src_cnt[10:0]] = v;
    src_cnt++;
  endtask

  task automatic set_coef_all(input logic signed [31:0] v);
    for (int i = 0; i < 32; i++) coef[i] = v;
  endtask

  task automatic wait_push(input string tag, output logic [31:0] y, output int at);
    logic found = 1'b0;
    y  = '0;
    at = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      if (y_out_wr_en) begin
        found = 1'b1;
        y     = y_out;
        at    = cyc;
      end
    end
    check({tag, " push seen"}, 32'(found), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " x_in_rd_en"}, 32'(x_in_rd_en), 32'd0);
    check({tag, " hist_wr_en"}, 32'(hist_wr_en), 32'd0);
    check({tag, " y_out_wr_en"}, 32'(y_out_wr_en), 32'd0);
    check({tag, " y_out"}, y_out, 32'd0);
    check({tag, " coeff_addr"}, 32'(coeff_addr), 32'd0);
    check({tag, " hist_rd_addr"}, 32'(hist_rd_addr), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0]        y;
    int                 at, prev_at, rel, pushes, base;
    logic               seen;
    logic signed [68:0] acc;
    longint             prod;

    reset = 1'b1; y_out_full = 1'b0; ram_fill = 1'b1; ram_fill_val = 32'sh7FFFFFFF;
    set_coef_all(32'sd1);
    @(negedge clk);
    ram_fill = 1'b0;
    feed(32'sd1024); feed(32'sd1024);
    @(negedge clk);
    check_idle("reset");
    rel = cyc;
    reset = 1'b0;

    // Startup masking over preloaded garbage, plus first-result latency.
    wait_push("mask", y, at);
    check("mask y_out", y, 32'd2);
    check("mask latency", 32'(at - rel), 32'd35);

    // Impulse with coefficients 1..32.
    do_reset();
    for (int i = 0; i < 32; i++) coef[i] = 32'(i + 1);
    feed(32'sd1024);
    for (int i = 0; i < 63; i++) feed(32'sd0);
    for (int j = 0; j < 32; j++) begin
      wait_push($sformatf("impulse[%0d]", j), y, at);
      check($sformatf("impulse[%0d] y_out", j), y, (j < 16) ? 32'(2 * j + 2) : 32'd0);
    end

    // Negative values through the newest tap.
    do_reset();
    set_coef_all(32'sd0);
    coef[0] = -32'sd3;
    feed(32'sd0); feed(-32'sd2048);
    wait_push("neg1", y, at);
    check("neg1 y_out", y, 32'd6);
    @(negedge clk);
    coef[0] = 32'sd3;
    feed(32'sd0); feed(-32'sd2048);
    wait_push("neg2", y, at);
    check("neg2 y_out", y, 32'hFFFF_FFFA);

    // Output backpressure held for 50 cycles in OUT.
    do_reset();
    set_coef_all(32'sd1);
    y_out_full = 1'b1;
    feed(32'sd1024); feed(32'sd2048); feed(32'sd4096); feed(32'sd4096);
    repeat (40) @(negedge clk);
    check("bp y_out", y_out, 32'd3);
    for (int i = 0; i < 50; i++) begin
      check("bp y_out_wr_en", 32'(y_out_wr_en), 32'd0);
      check("bp x_in_rd_en", 32'(x_in_rd_en), 32'd0);
      check("bp y_out stable", y_out, 32'd3);
      check("bp busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    y_out_full = 1'b0;
    #1;
    pushes = 0;
    for (int i = 0; i < 30; i++) begin
      if (y_out_wr_en) pushes++;
      @(negedge clk);
    end
    check("bp single push", 32'(pushes), 32'd1);
    wait_push("bp second", y, at);
    check("bp second y_out", y, 32'd11);

    // Reset while the MAC walk is at tap 10.
    feed(32'sh0010_0000); feed(32'sh0010_0000);
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (busy && coeff_addr == 5'd10) seen = 1'b1;
    end
    check("rst_mac reached k=10", 32'(seen), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_idle("rst_mac");
    @(negedge clk);
    check("rst_mac hold y_out_wr_en", 32'(y_out_wr_en), 32'd0);
    reset = 1'b0;
    feed(32'sd3072); feed(32'sd1024);
    wait_push("rst_mac next", y, at);
    check("rst_mac next y_out", y, 32'd4);

    // Random stream against a direct convolution model.
    do_reset();
    for (int i = 0; i < 32; i++) coef[i] = $urandom;
    base = src_cnt;
    for (int i = 0; i < 1000; i++) feed($urandom);
    prev_at = 0;
    for (int j = 0; j < 500; j++) begin
      acc = '0;
      for (int k = 0; k < 32 && k < 2 * j + 2; k++) begin
        prod = longint'(src[11'(base + 2 * j + 1 - k)]) * longint'(coef[k]);
        acc  = acc + 69'(prod);
      end
      wait_push($sformatf("stream[%0d]", j), y, at);
      check($sformatf("stream[%0d] y_out", j), y, 32'(acc >>> 10));
      if (j > 0) check($sformatf("stream[%0d] spacing", j), 32'(at - prev_at), 32'd36);
      prev_at = at;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
